// File: rtl/axis_upsizer.sv
// AXI-Stream width upsizer: packs RATIO narrow beats into one wide beat, lane 0 first.
// Define AXIS_UPSIZER_TLAST_EN to add s_axis_tlast with early flush and partial tkeep.
module axis_upsizer #(
  parameter int S_DATA_WIDTH = 8,
  parameter int RATIO        = 4
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [S_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
`ifdef AXIS_UPSIZER_TLAST_EN
  input  logic                          s_axis_tlast,
`endif
  output logic [S_DATA_WIDTH*RATIO-1:0] m_axis_tdata,
  output logic [RATIO-1:0]              m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast
);

  localparam int M_DATA_WIDTH = S_DATA_WIDTH * RATIO;
  localparam int IDX_W        = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int ACC_W        = (RATIO > 1) ? S_DATA_WIDTH * (RATIO - 1) : S_DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if (RATIO < 2 || S_DATA_WIDTH < 1) begin : g_param_check
    $error("axis_upsizer: RATIO must be >= 2 and S_DATA_WIDTH >= 1");
  end

  logic [IDX_W-1:0]        r_idx;
  logic [ACC_W-1:0]        r_acc;
  logic [M_DATA_WIDTH-1:0] r_m_tdata;
  logic                    r_m_tvalid;

  logic                    w_s_hs;
  logic                    w_m_hs;
  logic                    w_tlast;
  logic                    w_complete;
  logic [M_DATA_WIDTH-1:0] w_acc_ext;
  logic [M_DATA_WIDTH-1:0] w_word;

  assign s_axis_tready = aresetn && (!r_m_tvalid || m_axis_tready);
  assign w_s_hs        = s_axis_tvalid && s_axis_tready;
  assign w_m_hs        = r_m_tvalid && m_axis_tready;

`ifdef AXIS_UPSIZER_TLAST_EN
  assign w_tlast = s_axis_tlast;
`else
  assign w_tlast = 1'b0;
`endif

  assign w_complete = w_s_hs && ((r_idx == LAST_IDX) || w_tlast);
  assign w_acc_ext  = {{(M_DATA_WIDTH-ACC_W){1'b0}}, r_acc};

  // Lanes above idx are forced to zero so a flushed partial word carries no stale data.
  always_comb begin
    w_word = '0;
    for (int l = 0; l < RATIO; l++) begin
      if (l < int'(r_idx)) begin
        w_word[l*S_DATA_WIDTH +: S_DATA_WIDTH] = w_acc_ext[l*S_DATA_WIDTH +: S_DATA_WIDTH];
      end else if (l == int'(r_idx)) begin
        w_word[l*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis_tdata;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (w_complete) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (w_s_hs) begin
      for (int l = 0; l < RATIO - 1; l++) begin
        if (int'(r_idx) == l) begin
          r_acc[l*S_DATA_WIDTH +: S_DATA_WIDTH] <= s_axis_tdata;
        end
      end
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
    end else if (w_complete) begin
      r_m_tdata  <= w_word;
      r_m_tvalid <= 1'b1;
    end else if (w_m_hs) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;

`ifdef AXIS_UPSIZER_TLAST_EN
  logic [RATIO-1:0] r_m_tkeep;
  logic             r_m_tlast;
  logic [RATIO-1:0] w_keep;

  always_comb begin
    w_keep = '0;
    for (int l = 0; l < RATIO; l++) begin
      w_keep[l] = (l <= int'(r_idx));
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_m_tkeep <= '0;
      r_m_tlast <= 1'b0;
    end else if (w_complete) begin
      r_m_tkeep <= w_keep;
      r_m_tlast <= w_tlast;
    end
  end

  assign m_axis_tkeep = r_m_tkeep;
  assign m_axis_tlast = r_m_tlast;
`else
  // Without tlast every word is full-width and packets are unbounded.
  assign m_axis_tkeep = '1;
  assign m_axis_tlast = 1'b0;
`endif

endmodule

// File: tb/tb_axis_upsizer.sv
// Directed self-checking bench for axis_upsizer (S_DATA_WIDTH=8, RATIO=4).
// TLAST cases run only when AXIS_UPSIZER_TLAST_EN is defined.
module tb_axis_upsizer;

  logic        aclk;
  logic        aresetn;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;

  int checks = 0;
  int errors = 0;
  int waits  = 0;
  logic [31:0] words[$];
  logic [31:0] held;

`ifdef AXIS_UPSIZER_TLAST_EN
  localparam logic [3:0] RST_KEEP = 4'h0;
`else
  localparam logic [3:0] RST_KEEP = 4'hF;
`endif

  axis_upsizer #(.S_DATA_WIDTH(8), .RATIO(4)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
`ifdef AXIS_UPSIZER_TLAST_EN
    .s_axis_tlast  (s_tlast),
`endif
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Records every accepted output word, sampled mid-cycle.
  always begin
    @(negedge aclk);
    #2;
    if (aresetn && m_tvalid && m_tready) words.push_back(m_tdata);
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    int cnt;
    @(negedge aclk);
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = l;
    #1;
    cnt = 0;
    while (!s_tready && cnt < 50) begin
      @(negedge aclk);
      #1;
      cnt++;
    end
    waits += cnt;
    if (cnt == 50) check("beat_accept_timeout", 32'(s_tready), 32'd1);
  endtask

  task automatic idle();
    @(negedge aclk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    #1;
  endtask

  initial begin
    aresetn  = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(negedge aclk);
    #1;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata",  m_tdata, 32'h0);
    check("rst_tkeep",  32'(m_tkeep), 32'(RST_KEEP));
    check("rst_tlast",  32'(m_tlast), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("post_rst_s_tready", 32'(s_tready), 32'd1);

    // Basic packing and one-cycle latency.
    beat(8'h11, 1'b0); beat(8'h22, 1'b0); beat(8'h33, 1'b0); beat(8'h44, 1'b0);
    check("w1_not_early", 32'(m_tvalid), 32'd0);
    idle();
    check("w1_tvalid", 32'(m_tvalid), 32'd1);
    check("w1_tdata",  m_tdata, 32'h44332211);
    check("w1_tkeep",  32'(m_tkeep), 32'hF);
    check("w1_tlast",  32'(m_tlast), 32'd0);
    idle();
    check("w1_consumed", 32'(m_tvalid), 32'd0);

    // Sustained throughput: 16 beats, no tready drop.
    words.delete();
    waits = 0;
    for (int i = 0; i < 16; i++) beat(8'(i), 1'b0);
    idle(); idle(); idle();
    check("stream_waits", 32'(waits), 32'd0);
    check("stream_count", 32'(words.size()), 32'd4);
    if (words.size() == 4) begin
      check("stream_w0", words[0], 32'h03020100);
      check("stream_w1", words[1], 32'h07060504);
      check("stream_w2", words[2], 32'h0B0A0908);
      check("stream_w3", words[3], 32'h0F0E0D0C);
    end

    // Backpressure: stall the first word for five cycles with a beat pending.
    words.delete();
    beat(8'h21, 1'b0); beat(8'h22, 1'b0); beat(8'h23, 1'b0); beat(8'h24, 1'b0);
    @(negedge aclk);
    m_tready = 1'b0;
    s_tdata  = 8'h31;
    s_tvalid = 1'b1;
    #1;
    check("stall_s_tready", 32'(s_tready), 32'd0);
    check("stall_tvalid",   32'(m_tvalid), 32'd1);
    check("stall_tdata",    m_tdata, 32'h24232221);
    held = m_tdata;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      #1;
      check("stall_hold_tdata",  m_tdata, held);
      check("stall_hold_ready",  32'(s_tready), 32'd0);
      check("stall_hold_tvalid", 32'(m_tvalid), 32'd1);
    end
    @(negedge aclk);
    m_tready = 1'b1;
    #1;
    check("release_s_tready", 32'(s_tready), 32'd1);
    beat(8'h32, 1'b0); beat(8'h33, 1'b0); beat(8'h34, 1'b0);
    idle();
    check("w2_tdata",  m_tdata, 32'h34333231);
    check("w2_tvalid", 32'(m_tvalid), 32'd1);
    idle(); idle();
    check("stall_count", 32'(words.size()), 32'd2);
    if (words.size() == 2) begin
      check("stall_word0", words[0], 32'h24232221);
      check("stall_word1", words[1], 32'h34333231);
    end

`ifdef AXIS_UPSIZER_TLAST_EN
    // Early flush after two lanes.
    beat(8'hAA, 1'b0); beat(8'hBB, 1'b1);
    idle();
    check("flush2_tdata", m_tdata, 32'h0000BBAA);
    check("flush2_tkeep", 32'(m_tkeep), 32'h3);
    check("flush2_tlast", 32'(m_tlast), 32'd1);
    beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0); beat(8'h04, 1'b0);
    idle();
    check("after_flush_tdata", m_tdata, 32'h04030201);
    check("after_flush_tkeep", 32'(m_tkeep), 32'hF);
    check("after_flush_tlast", 32'(m_tlast), 32'd0);
    // tlast coinciding with the last lane yields exactly one full word.
    idle(); idle();
    words.delete();
    beat(8'h41, 1'b0); beat(8'h42, 1'b0); beat(8'h43, 1'b0); beat(8'h44, 1'b1);
    idle();
    check("full_last_tdata", m_tdata, 32'h44434241);
    check("full_last_tkeep", 32'(m_tkeep), 32'hF);
    check("full_last_tlast", 32'(m_tlast), 32'd1);
    idle(); idle(); idle();
    check("full_last_count", 32'(words.size()), 32'd1);
    // tlast on the very first lane.
    beat(8'hCC, 1'b1);
    idle();
    check("flush1_tdata", m_tdata, 32'h000000CC);
    check("flush1_tkeep", 32'(m_tkeep), 32'h1);
    check("flush1_tlast", 32'(m_tlast), 32'd1);
    idle();
`endif

    // Reset mid-word discards the partial accumulation.
    beat(8'h55, 1'b0); beat(8'h66, 1'b0);
    @(negedge aclk);
    s_tvalid = 1'b0;
    aresetn  = 1'b0;
    #1;
    check("midrst_tvalid",   32'(m_tvalid), 32'd0);
    check("midrst_tdata",    m_tdata, 32'h0);
    check("midrst_tkeep",    32'(m_tkeep), 32'(RST_KEEP));
    check("midrst_tlast",    32'(m_tlast), 32'd0);
    check("midrst_s_tready", 32'(s_tready), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0); beat(8'h04, 1'b0);
    idle();
    check("postrst_tdata",  m_tdata, 32'h04030201);
    check("postrst_tkeep",  32'(m_tkeep), 32'hF);
    check("postrst_tvalid", 32'(m_tvalid), 32'd1);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
